// File: rtl/mult_div_sequencer_pkg.sv
// mult_div_sequencer_pkg: ALU control codes shared with the ALU decoder and the sequencer state encoding.
//   ALU_* : 3-bit ALU control codes
//   state_t : IDLE / CALC / FIX / DONE
package mult_div_sequencer_pkg;
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_MULT = 3'b010;
   localparam logic [2:0] ALU_DIV  = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/mult_div_sequencer_step.sv
// mult_div_sequencer_step: one combinational iteration of shift-add multiply or restoring divide.
//   is_div : 1 = divide step, 0 = multiply step
//   acc    : product upper half (mult) / partial remainder (div)
//   low    : multiplier bits still to consume (mult) / dividend bits and quotient (div)
//   opnd   : multiplicand (mult) / divisor (div)
//   acc_n, low_n : state after this iteration
module mult_div_sequencer_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] low,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] acc_n,
   output logic [WIDTH-1:0] low_n
);
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sub;
   logic             ge;
   assign sum = {1'b0, acc} + {1'b0, low[0] ? opnd : '0};
   // The shifted remainder is always < 2*divisor, so the W-bit difference is exact whenever ge holds.
   assign ge  = {acc, low[WIDTH-1]} >= {1'b0, opnd};
   assign sub = {acc[WIDTH-2:0], low[WIDTH-1]} - opnd;
   always_comb begin
      acc_n = is_div ? (ge ? sub : {acc[WIDTH-2:0], low[WIDTH-1]}) : sum[WIDTH:1];
      low_n = is_div ? {low[WIDTH-2:0], ge} : {sum[0], low[WIDTH-1:1]};
   end
endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle signed multiply/divide writing a 64-bit result to HI/LO.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start, alu_con, op_a, op_b : request, ALU code, signed operands
//   busy, done, div_zero : in-flight, one-cycle completion pulse, sticky divide-by-zero
//   hi, lo : result registers
module mult_div_sequencer
   import mult_div_sequencer_pkg::*;
#(
   parameter int         WIDTH     = 32,
   parameter logic [2:0] MULT_CODE = ALU_MULT,
   parameter logic [2:0] DIV_CODE  = ALU_DIV
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       alu_con,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   state_t             state, state_n;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   acc, low, opb, acc_s, low_s, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic               is_div, sa, sb, accept, dz;
   assign accept = start && state == IDLE && (alu_con == MULT_CODE || alu_con == DIV_CODE);
   assign dz     = alu_con == DIV_CODE && op_b == '0;
   assign busy   = accept || state == CALC || state == FIX;
   assign done   = state == DONE;
   mult_div_sequencer_step #(.WIDTH(WIDTH)) u_step (
      .is_div (is_div),
      .acc    (acc),
      .low    (low),
      .opnd   (opb),
      .acc_n  (acc_s),
      .low_n  (low_s)
   );
   // Remainder follows the dividend's sign; quotient and product follow sign_a ^ sign_b.
   always_comb begin
      prod_fix = (sa ^ sb) ? -{acc, low} : {acc, low};
      fix_hi   = is_div ? (sa ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = is_div ? ((sa ^ sb) ? -low : low) : prod_fix[WIDTH-1:0];
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = dz ? DONE : CALC;
         CALC:    if (cnt == CW'(WIDTH - 1)) state_n = FIX;
         FIX:     state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         low      <= '0;
         opb      <= '0;
         is_div   <= 1'b0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            is_div   <= alu_con == DIV_CODE;
            sa       <= op_a[WIDTH-1];
            sb       <= op_b[WIDTH-1];
            cnt      <= '0;
            acc      <= '0;
            low      <= op_a[WIDTH-1] ? -op_a : op_a;
            opb      <= op_b[WIDTH-1] ? -op_b : op_b;
            div_zero <= dz;
            if (dz) begin
               hi <= op_a;
               lo <= '1;
            end
         end else if (state == CALC) begin
            acc <= acc_s;
            low <= low_s;
            cnt <= cnt + 1'b1;
         end
         // Loading on the FIX->DONE edge makes hi/lo valid in the same cycle done is high.
         if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end
      end
   end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed self-checking bench for mult_div_sequencer.
module tb_mult_div_sequencer;
   logic        clock, reset, start, busy, done, div_zero;
   logic [2:0]  alu_con;
   logic [31:0] op_a, op_b, hi, lo;
   int          total = 0;
   int          bad = 0;

   mult_div_sequencer dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .alu_con  (alu_con),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic kick(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, output logic bt);
      alu_con = c;
      op_a    = a;
      op_b    = b;
      start   = 1'b1;
      #1 bt   = busy;
      cyc();
      start   = 1'b0;
   endtask

   task automatic wait_done(output int n, output logic ball);
      n    = 1;
      ball = 1'b1;
      while (done !== 1'b1 && n < 100) begin
         if (busy !== 1'b1) ball = 1'b0;
         cyc();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      alu_con = 3'b000;
      op_a = '0;
      op_b = '0;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      total++; if ({busy, done, div_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_zero}); end
      total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
   endtask

   task automatic test_mult();
      int n;
      logic bt, ball;
      kick(3'b010, 32'd7, 32'hFFFF_FFFD, bt);
      wait_done(n, ball);
      total++; if (bt !== 1'b1) begin bad++; $display("FAIL mult_busy_T got=%b exp=1", bt); end
      total++; if (ball !== 1'b1) begin bad++; $display("FAIL mult_busy_span got=%b exp=1", ball); end
      total++; if (n !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", n); end
      total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_7x-3 got=%h exp=ffffffffffffffeb", {hi, lo}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_done got=%b exp=0", busy); end
      cyc();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_div();
      int n;
      logic bt, ball;
      kick(3'b011, 32'hFFFF_FFF9, 32'd2, bt);
      wait_done(n, ball);
      total++; if (n !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", n); end
      total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_-7/2 got=%h exp=fffffffffffffffd", {hi, lo}); end
      cyc();
      kick(3'b011, 32'd100, 32'd7, bt);
      wait_done(n, ball);
      total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL div_100/7 got=%h exp=%h", {hi, lo}, {32'd2, 32'd14}); end
      cyc();
      kick(3'b011, 32'd7, 32'hFFFF_FFFE, bt);
      wait_done(n, ball);
      total++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_7/-2 got=%h exp=00000001fffffffd", {hi, lo}); end
      cyc();
   endtask

   task automatic test_div_zero();
      int n;
      logic bt, ball;
      kick(3'b011, 32'd5, 32'd0, bt);
      wait_done(n, ball);
      total++; if (n !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", n); end
      total++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL dz_hilo got=%h exp=00000005ffffffff", {hi, lo}); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
      cyc();
      cyc();
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b exp=1", div_zero); end
      kick(3'b010, 32'd3, 32'd4, bt);
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
      wait_done(n, ball);
      total++; if ({hi, lo} !== 64'd12) begin bad++; $display("FAIL dz_next_mult got=%h exp=c", {hi, lo}); end
      cyc();
   endtask

   task automatic test_ignored();
      int pulses, first;
      logic bt;
      pulses = 0;
      first = 0;
      kick(3'b010, 32'd6, 32'd5, bt);
      for (int i = 1; i <= 45; i++) begin
         if (i == 5) begin
            alu_con = 3'b011;
            op_a = 32'd99;
            op_b = 32'd0;
            start = 1'b1;
         end else if (i == first + 1 && first != 0) begin
            start = 1'b0;
         end else if (i == 6) begin
            start = 1'b0;
         end
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = i;
               alu_con = 3'b010;
               op_a = 32'd11;
               op_b = 32'd11;
               start = 1'b1;
            end
         end
         cyc();
      end
      start = 1'b0;
      total++; if (pulses !== 1) begin bad++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
      total++; if (first !== 34) begin bad++; $display("FAIL ign_latency got=%0d exp=34", first); end
      total++; if ({hi, lo} !== 64'd30) begin bad++; $display("FAIL ign_result got=%h exp=1e", {hi, lo}); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL ign_dz got=%b exp=0", div_zero); end
      alu_con = 3'b000;
      op_a = 32'd1;
      op_b = 32'd2;
      start = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_add_busy got=%b exp=0", busy); end
      cyc();
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) pulses++;
         cyc();
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL ign_add_activity got=%0d exp=0", pulses); end
      total++; if ({hi, lo} !== 64'd30) begin bad++; $display("FAIL ign_add_hilo got=%h exp=1e", {hi, lo}); end
   endtask

   task automatic test_reset_abort();
      int n;
      logic bt, ball;
      kick(3'b011, 32'd100, 32'd7, bt);
      for (int i = 1; i < 10; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b exp=00", {busy, done}); end
      total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL abort_hilo got=%h exp=0", {hi, lo}); end
      kick(3'b010, 32'h8000_0000, 32'd2, bt);
      wait_done(n, ball);
      total++; if (n !== 34) begin bad++; $display("FAIL abort_mult_latency got=%0d exp=34", n); end
      total++; if ({hi, lo} !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL abort_mult got=%h exp=ffffffff00000000", {hi, lo}); end
      cyc();
   endtask

   task automatic test_back_to_back();
      int n;
      logic bt, ball;
      kick(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, bt);
      wait_done(n, ball);
      total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL b2b_minint got=%h exp=0000000080000000", {hi, lo}); end
      cyc();
      kick(3'b011, 32'd100, 32'd7, bt);
      total++; if (bt !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", bt); end
      wait_done(n, ball);
      total++; if (n !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", n); end
      total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL b2b_result got=%h exp=%h", {hi, lo}, {32'd2, 32'd14}); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Multi-cycle sequencer for the ALU's multiply and divide operations (ALU control codes 3'b010 mult, 3'b011 div).
- Captures the operands on a start pulse, then runs a 32-step iterative shift-add multiply or restoring divide.
- Applies sign fix-up and writes the 64-bit result to the HI/LO registers.
- Raises busy so the CPU control FSM stalls until done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MULT_CODE, 3'b010, ALU control code that selects multiply.
- DIV_CODE, 3'b011, ALU control code that selects divide.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse from CPU control; sampled only in IDLE.
- alu_con  in  3  ALU control code from the ALU decoder.
- op_a  in  WIDTH  rs value (multiplicand / dividend), signed.
- op_b  in  WIDTH  rt value (multiplier / divisor), signed.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO hold a new result.
- div_zero  out  1  sticky until the next accepted start; set when divisor was 0.
- hi  out  WIDTH  HI register: product upper half / remainder.
- lo  out  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; step counter=0.
- Reset is synchronous. Asserting it mid-operation aborts the operation and restores all reset values on the next edge. No partial result is written.
- Accept rule: start=1 in IDLE with alu_con in {MULT_CODE, DIV_CODE}.
  - Any other alu_con value, or start while busy, is ignored with no side effects.
- On accept at edge T:
  - Latch abs(op_a), abs(op_b), op type, and the sign bits.
  - Clear div_zero.
  - Step counter=0; busy=1 from T.
- States:
  - IDLE -> CALC on accept. Exception: divide with op_b==0 goes IDLE -> DONE.
  - CALC: one step per cycle for WIDTH cycles (counter 0..WIDTH-1), then -> FIX.
  - FIX: one cycle; conditionally negate the result, then -> DONE.
  - DONE: one cycle; write hi/lo, done=1, busy=0, then -> IDLE.
- Latency:
  - Normal: accept at T; CALC T+1..T+32; FIX T+33; DONE T+34. done is high in cycle T+34 and hi/lo are valid from that cycle.
  - Divide-by-zero: done is high at T+1.
  - A new start is accepted in the cycle after DONE at the earliest. start asserted during DONE is ignored.
- Multiply:
  - Unsigned 64-bit shift-add on the magnitudes.
  - Negate the full 64-bit product if sign_a XOR sign_b.
  - {hi, lo} = product.
- Divide:
  - Restoring division on the magnitudes: quotient q, remainder r.
  - Negate q if sign_a XOR sign_b; negate r if sign_a (remainder takes the dividend's sign; quotient truncates toward zero).
  - lo = q, hi = r.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero:
  - hi = op_a, lo = 32'hFFFF_FFFF, div_zero=1.
  - div_zero stays high until the next accept.
- hi/lo change only in DONE and on reset; they hold their values at all other times.

Decomposition:
- Shared package holds:
  - ALU control code constants (ADD 3'b000, SUB 3'b001, MULT 3'b010, DIV 3'b011, SLT 3'b100), so these codes stay consistent with the ALU decoder.
  - The state encoding IDLE/CALC/FIX/DONE.
- One sub-module is natural: mult_div_step, a combinational single-iteration datapath.
  - Multiply step: conditional add and shift.
  - Divide step: trial subtract, restore, and quotient bit.
  - The sequencer owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- mult 7 × -3 (op_a=7, op_b=0xFFFFFFFD) -> done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T..T+33.
- div -7 / 2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+34; div 100 / 7 -> lo=14, hi=2.
- div 5 / 0 -> done at T+1; hi=5, lo=0xFFFFFFFF, div_zero=1; next accepted mult clears div_zero.
- start pulsed at T+5 during a mult, and start with alu_con=3'b000 in IDLE -> both ignored; only one done pulse; hi/lo unchanged by the ignored requests.
- reset=1 at T+10 during a div -> next cycle busy=0, done=0, hi=lo=0, state IDLE; a new mult 0x80000000 × 2 -> hi=0xFFFFFFFF, lo=0.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; back-to-back: a start in the cycle after DONE is accepted and yields a correct second result.
